// File: rtl/fmap_stream_src.sv
// Raster-order feature-map source: reads one pixel word per address from a 1-cycle RAM
// and streams it with row/col tags through a 2-entry FIFO that absorbs read latency and stalls.
module fmap_stream_src #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int CH     = 64,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [CH*DATA_W-1:0] mem_rd_data,
  input  logic                 o_ready,
  output logic                 o_data_valid,
  output logic [CH*DATA_W-1:0] o_data,
  output logic [15:0]          o_row,
  output logic [15:0]          o_col,
  output logic                 o_last
);

  localparam int PIX_W = CH * DATA_W;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [15:0] COL_MAX = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_MAX = 16'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_e;

  state_e              state_q;
  logic                busy_q, done_q;
  logic [ADDR_W-1:0]   base_q;
  logic [IDX_W-1:0]    rd_idx_q;
  logic                inflight_q;
  logic [PIX_W-1:0]    fifo_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q, count_d;
  logic [15:0]         row_q, col_q, row_d, col_d;
  logic [2:0]          occ_s;
  logic                pop_s, push_s, last_s, last_pop_s, rd_en_s;

  assign pop_s      = (count_q != 2'd0) && o_ready;
  assign push_s     = inflight_q;
  assign last_s     = (row_q == ROW_MAX) && (col_q == COL_MAX);
  assign last_pop_s = pop_s && last_s;

  // Read throttle: FIFO plus in-flight slot may never exceed two words after this cycle's pop.
  always_comb begin
    occ_s = {1'b0, count_q} + {2'b00, inflight_q};
    if ((state_q == S_STREAM) && (rd_idx_q < IDX_END) && (occ_s < (3'd2 + {2'b00, pop_s}))) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Frame controller with registered busy/done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_STREAM;
            busy_q  <= 1'b1;
            base_q  <= base_addr;
          end
        end
        S_STREAM: begin
          if (last_pop_s) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read index and the one-cycle in-flight marker for the RAM latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
    end else if (last_pop_s) begin
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en_s;
      if (rd_en_s) begin
        rd_idx_q <= rd_idx_q + IDX_ONE;
      end
    end
  end

  // FIFO occupancy next state.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Two-entry FIFO; emptied on reset and when the frame completes.
  always_ff @(posedge clk) begin
    if (!rst || last_pop_s) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= mem_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Raster position of the FIFO head, advanced per handshake.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (pop_s) begin
      if (col_q == COL_MAX) begin
        col_d = 16'd0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end else begin
      col_d = col_q;
    end
  end

  // Position counters register.
  always_ff @(posedge clk) begin
    if (!rst || last_pop_s) begin
      row_q <= 16'd0;
      col_q <= 16'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_rd_en    = rd_en_s;
  assign mem_rd_addr  = base_q + ADDR_W'(rd_idx_q);
  assign o_data_valid = (count_q != 2'd0);
  assign o_data       = fifo_q[rd_ptr_q];
  assign o_row        = row_q;
  assign o_col        = col_q;
  assign o_last       = last_s;

  fmap_stream_src_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_q)
  );

endmodule

// FIFO overflow checker: a push into a full FIFO without a pop must never happen.
module fmap_stream_src_chk (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && !pop && (count == 2'd2)));
endmodule
